compare_result_tally: RTL and testbench
=======================================

Name: compare_result_tally

Overview:
- Downstream consumer of the 2-bit magnitude comparator's 3-bit result bus.
- Counts greater/equal/less outcomes and illegal (non-one-hot) codes in saturating counters.
- On request, snapshots all four counts and streams them out over a valid/ready report channel.
- Acts as the self-checking statistics stage behind the comparator in exhaustive-sweep and board bring-up.

Parameters:
- CNT_W, 8, width of each counter and of rpt_data; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  cmp_out is a valid sample this cycle; no backpressure.
- cmp_out  in  3  comparator result: [2] a>b, [1] a==b, [0] a<b.
- clear  in  1  synchronous clear of all counters and error state.
- report_req  in  1  start report; sampled only in IDLE.
- rpt_ready  in  1  report consumer accepts the current beat.
- rpt_valid  out  1  report beat valid.
- rpt_sel  out  2  beat identifier: 0=GT, 1=EQ, 2=LT, 3=ERR.
- rpt_data  out  CNT_W  snapshotted count for rpt_sel.
- busy  out  1  high while in REPORT.
- err_flag  out  1  illegal-code indication (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): all counters and snapshots 0; state IDLE; rpt_valid=0, rpt_sel=0, rpt_data=0, busy=0, err_flag=0. Asserting rst_n mid-report aborts the report immediately.
- Sampling: every cycle with in_valid=1 updates exactly one counter at the next edge (1-cycle latency).
  - 3'b100 -> cnt_gt; 3'b010 -> cnt_eq; 3'b001 -> cnt_lt.
  - Any other code (000, 011, 101, 110, 111) -> cnt_err.
- Saturation: a counter at 2^CNT_W-1 holds; no wrap-around.
- clear: zeroes all counters and err_flag at the next edge.
  - Takes priority over a same-cycle in_valid sample; that sample is dropped.
  - In REPORT: aborts to IDLE; rpt_valid=0 and busy=0 next cycle.
  - Snapshot registers are not cleared.
- FSM states: IDLE, REPORT.
  - IDLE -> REPORT on report_req=1 (and clear=0).
    - Snapshot = counter register values at that edge; a same-cycle sample is excluded from the snapshot but is counted.
    - Next cycle: rpt_valid=1, rpt_sel=0, busy=1.
  - REPORT: a beat is accepted on rpt_valid&rpt_ready.
    - On acceptance rpt_sel increments; rpt_data shows the matching snapshot.
    - Acceptance of beat 3 -> IDLE, with rpt_valid=0 and busy=0 next cycle.
    - rpt_sel and rpt_data hold stable while rpt_valid=1 and rpt_ready=0.
  - report_req is ignored in REPORT.
  - Sampling continues in REPORT; live counters update, the snapshot does not.
- Minimum report duration: 4 cycles with rpt_ready held high.

Optional Feature:
- Macro: COMPARE_TALLY_STICKY_ERR_EN.
- Defined: err_flag is sticky. It sets on the edge after the first illegal sample and stays 1 until clear or reset.
- Undefined: err_flag is a registered 1-cycle pulse on the edge after each illegal sample.
- cnt_err behaviour is identical in both builds.

Decomposition:
- Package compare_pkg:
  - CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
  - Report select codes SEL_GT..SEL_ERR.
  - FSM state encoding (IDLE, REPORT).
- Sub-module compare_sat_counter (CNT_W; inputs clk, rst_n, clr, inc; output count), instantiated 4 times.

Test Plan:
- Reset then drive all 16 (a,b) comparator results once, report with rpt_ready=1 -> beats (0,6),(1,4),(2,6),(3,0); busy high exactly 4 cycles.
- Inject cmp_out=3'b000 and 3'b111 -> cnt_err=2.
  - Sticky build: err_flag=1 until clear.
  - Non-sticky build: two 1-cycle pulses.
- CNT_W=2, drive 5 GT samples -> reported GT count=3 (saturated).
- Report with rpt_ready low 3 cycles on beat 1 while feeding 2 EQ samples -> beat 1 data/sel stable; reported EQ equals the snapshot value; a second report shows +2.
- clear asserted on the same cycle as in_valid=1 with cmp_out=3'b100 -> report shows all zeros; clear mid-report -> rpt_valid=0 next cycle, state IDLE.
- rst_n pulled low asynchronously during beat 2 -> rpt_valid, busy, and all counts 0 without waiting for a clock edge.

Source files
------------

// File: rtl/compare_result_tally_pkg.sv
// Shared codes for the comparator tally stage: comparator result encodings,
// report beat selects and the report FSM state type.
package compare_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    localparam int unsigned NUM_CNT = 4;

    typedef enum logic [1:0] {
        SEL_GT  = 2'd0,
        SEL_EQ  = 2'd1,
        SEL_LT  = 2'd2,
        SEL_ERR = 2'd3
    } rpt_sel_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } tally_state_e;

    // Maps a comparator result to the counter it feeds; non-one-hot goes to ERR.
    function automatic rpt_sel_e code_to_sel(input logic [2:0] code);
        rpt_sel_e sel;
        case (code)
            CMP_GT:  sel = SEL_GT;
            CMP_EQ:  sel = SEL_EQ;
            CMP_LT:  sel = SEL_LT;
            default: sel = SEL_ERR;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/compare_result_tally_if.sv
// Sample input and report channel bundle for compare_result_tally.
// master drives samples/commands and consumes the report; slave is the tally.
interface compare_result_tally_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic [2:0]       cmp_out;
    logic             clear;
    logic             report_req;
    logic             rpt_ready;
    logic             rpt_valid;
    logic [1:0]       rpt_sel;
    logic [CNT_W-1:0] rpt_data;
    logic             busy;
    logic             err_flag;

    modport master (
        output in_valid, cmp_out, clear, report_req, rpt_ready,
        input  rpt_valid, rpt_sel, rpt_data, busy, err_flag
    );

    modport slave (
        input  in_valid, cmp_out, clear, report_req, rpt_ready,
        output rpt_valid, rpt_sel, rpt_data, busy, err_flag
    );
endinterface

// File: rtl/compare_result_tally_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module compare_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/compare_result_tally.sv
// Tallies comparator results into GT/EQ/LT/ERR saturating counters and streams
// a snapshot over a valid/ready report channel. COMPARE_TALLY_STICKY_ERR_EN makes err_flag sticky.
module compare_result_tally
    import compare_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    compare_result_tally_if.slave   bus
);

    logic [NUM_CNT-1:0] inc;
    logic               illegal;
    logic [CNT_W-1:0]   cnt    [NUM_CNT];
    logic [CNT_W-1:0]   snap_q [NUM_CNT];
    logic               snap_load;

    tally_state_e state_q, state_d;
    rpt_sel_e     sel_q,   sel_d;
    logic         err_q,   err_d;

    // clear wins over a same-cycle sample, so the sample never reaches a counter.
    always_comb begin
        inc     = '0;
        illegal = 1'b0;
        if (bus.in_valid && !bus.clear) begin
            inc[code_to_sel(bus.cmp_out)] = 1'b1;
            illegal = (code_to_sel(bus.cmp_out) == SEL_ERR);
        end
    end

    compare_sat_counter #(.CNT_W(CNT_W)) u_cnt_gt (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(inc[SEL_GT]), .count(cnt[SEL_GT])
    );
    compare_sat_counter #(.CNT_W(CNT_W)) u_cnt_eq (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(inc[SEL_EQ]), .count(cnt[SEL_EQ])
    );
    compare_sat_counter #(.CNT_W(CNT_W)) u_cnt_lt (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(inc[SEL_LT]), .count(cnt[SEL_LT])
    );
    compare_sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(inc[SEL_ERR]), .count(cnt[SEL_ERR])
    );

    always_comb begin
`ifdef COMPARE_TALLY_STICKY_ERR_EN
        err_d = bus.clear ? 1'b0 : (err_q | illegal);
`else
        err_d = illegal;
`endif
    end

    // In REPORT rpt_valid is always high, so rpt_ready alone means acceptance.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        snap_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.report_req && !bus.clear) begin
                    state_d   = ST_REPORT;
                    sel_d     = SEL_GT;
                    snap_load = 1'b1;
                end
            end
            ST_REPORT: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_GT;
                end else if (bus.rpt_ready) begin
                    if (sel_q == SEL_ERR) begin
                        state_d = ST_IDLE;
                        sel_d   = SEL_GT;
                    end else begin
                        sel_d = rpt_sel_e'(sel_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_GT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_GT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                snap_q[i] <= '0;
            end
        end else if (snap_load) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                snap_q[i] <= cnt[i];
            end
        end
    end

    assign bus.rpt_valid = (state_q == ST_REPORT);
    assign bus.busy      = (state_q == ST_REPORT);
    assign bus.rpt_sel   = sel_q;
    assign bus.rpt_data  = snap_q[sel_q];
    assign bus.err_flag  = err_q;

endmodule

// File: tb/tb_compare_result_tally.sv
// Scoreboard bench for compare_result_tally: 8-bit and 2-bit counter instances.
module tb_compare_result_tally;
    import compare_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    compare_result_tally_if #(.CNT_W(8)) bus8 ();
    compare_result_tally_if #(.CNT_W(2)) bus2 ();

    compare_result_tally #(.CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    compare_result_tally #(.CNT_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int total = 0;
    int bad   = 0;

    logic [9:0] q8[$];
    logic [3:0] q2[$];

    always @(negedge clk) begin
        if (rst_n && bus8.rpt_valid && bus8.rpt_ready) begin
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL beat8_unexpected: got sel=%0d data=%0d, required none", bus8.rpt_sel, bus8.rpt_data);
            end else begin
                logic [9:0] e;
                e = q8.pop_front();
                if ({bus8.rpt_sel, bus8.rpt_data} !== e) begin
                    bad++;
                    $display("FAIL beat8: got sel=%0d data=%0d, required sel=%0d data=%0d",
                             bus8.rpt_sel, bus8.rpt_data, e[9:8], e[7:0]);
                end
            end
        end
        if (rst_n && bus2.rpt_valid && bus2.rpt_ready) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL beat2_unexpected: got sel=%0d data=%0d, required none", bus2.rpt_sel, bus2.rpt_data);
            end else begin
                logic [3:0] e;
                e = q2.pop_front();
                if ({bus2.rpt_sel, bus2.rpt_data} !== e) begin
                    bad++;
                    $display("FAIL beat2: got sel=%0d data=%0d, required sel=%0d data=%0d",
                             bus2.rpt_sel, bus2.rpt_data, e[3:2], e[1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic sample8(input logic [2:0] c);
        bus8.in_valid = 1'b1;
        bus8.cmp_out  = c;
        step();
        bus8.in_valid = 1'b0;
    endtask

    task automatic push8(input logic [1:0] s, input logic [7:0] d);
        q8.push_back({s, d});
    endtask

    task automatic wait_idle8(output int cyc);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus8.busy) break;
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_report8(input string name, input int exp_busy);
        int cyc;
        bus8.report_req = 1'b1;
        bus8.rpt_ready  = 1'b1;
        step();
        bus8.report_req = 1'b0;
        wait_idle8(cyc);
        check({name, "_busy"}, cyc, exp_busy);
        check({name, "_drain"}, q8.size(), 0);
    endtask

    initial begin
        int cyc;
        {bus8.in_valid, bus8.cmp_out, bus8.clear, bus8.report_req, bus8.rpt_ready} = '0;
        {bus2.in_valid, bus2.cmp_out, bus2.clear, bus2.report_req, bus2.rpt_ready} = '0;
        #12;
        check("rst_valid", bus8.rpt_valid, 0);
        check("rst_sel", bus8.rpt_sel, 0);
        check("rst_data", bus8.rpt_data, 0);
        check("rst_busy", bus8.busy, 0);
        check("rst_err", bus8.err_flag, 0);
        rst_n = 1'b1;
        step();

        // all 16 (a,b) pairs: 6 GT, 4 EQ, 6 LT
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                sample8((a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001);
            end
        end
        push8(0, 6); push8(1, 4); push8(2, 6); push8(3, 0);
        run_report8("sweep", 4);

        // illegal codes
        sample8(3'b000);
        check("err_after_000", bus8.err_flag, 1);
        step();
`ifdef COMPARE_TALLY_STICKY_ERR_EN
        check("err_hold_1", bus8.err_flag, 1);
`else
        check("err_pulse_end_1", bus8.err_flag, 0);
`endif
        sample8(3'b111);
        check("err_after_111", bus8.err_flag, 1);
        step();
`ifdef COMPARE_TALLY_STICKY_ERR_EN
        check("err_hold_2", bus8.err_flag, 1);
`else
        check("err_pulse_end_2", bus8.err_flag, 0);
`endif
        push8(0, 6); push8(1, 4); push8(2, 6); push8(3, 2);
        run_report8("errcnt", 4);
        bus8.clear = 1'b1;
        step();
        bus8.clear = 1'b0;
        check("err_after_clear", bus8.err_flag, 0);

        // 2-bit counters saturate at 3
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.cmp_out  = 3'b100;
            step();
        end
        bus2.in_valid = 1'b0;
        q2.push_back({2'd0, 2'd3}); q2.push_back({2'd1, 2'd0});
        q2.push_back({2'd2, 2'd0}); q2.push_back({2'd3, 2'd0});
        bus2.report_req = 1'b1;
        bus2.rpt_ready  = 1'b1;
        step();
        bus2.report_req = 1'b0;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus2.busy) break;
            cyc++;
        end
        step();
        check("sat_busy", cyc, 4);
        check("sat_drain", q2.size(), 0);

        // backpressure on beat 1 while sampling continues
        sample8(3'b100);
        sample8(3'b010); sample8(3'b010); sample8(3'b010);
        sample8(3'b001);
        push8(0, 1); push8(1, 3); push8(2, 1); push8(3, 0);
        bus8.report_req = 1'b1;
        bus8.rpt_ready  = 1'b1;
        step();
        bus8.report_req = 1'b0;
        step();
        bus8.rpt_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.cmp_out   = 3'b010;
        for (int h = 0; h < 3; h++) begin
            if (h == 2) bus8.in_valid = 1'b0;
            step();
            check("hold_sel", bus8.rpt_sel, 1);
            check("hold_data", bus8.rpt_data, 3);
            check("hold_valid", bus8.rpt_valid, 1);
        end
        bus8.in_valid  = 1'b0;
        bus8.rpt_ready = 1'b1;
        wait_idle8(cyc);
        check("hold_rest_busy", cyc, 3);
        push8(0, 1); push8(1, 5); push8(2, 1); push8(3, 0);
        run_report8("second", 4);

        // clear beats a same-cycle sample
        bus8.clear    = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.cmp_out  = 3'b100;
        step();
        bus8.clear    = 1'b0;
        bus8.in_valid = 1'b0;
        push8(0, 0); push8(1, 0); push8(2, 0); push8(3, 0);
        run_report8("cleared", 4);

        // clear aborts a report after beat 0
        sample8(3'b001); sample8(3'b001);
        push8(0, 0);
        bus8.report_req = 1'b1;
        bus8.rpt_ready  = 1'b1;
        step();
        bus8.report_req = 1'b0;
        step();
        bus8.rpt_ready = 1'b0;
        bus8.clear     = 1'b1;
        step();
        bus8.clear = 1'b0;
        check("abort_valid", bus8.rpt_valid, 0);
        check("abort_busy", bus8.busy, 0);
        check("abort_drain", q8.size(), 0);

        // asynchronous reset during beat 2
        sample8(3'b100); sample8(3'b100); sample8(3'b100);
        push8(0, 3); push8(1, 0);
        bus8.report_req = 1'b1;
        bus8.rpt_ready  = 1'b1;
        step();
        bus8.report_req = 1'b0;
        step();
        step();
        bus8.rpt_ready = 1'b0;
        check("arst_pre_sel", bus8.rpt_sel, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", bus8.rpt_valid, 0);
        check("arst_busy", bus8.busy, 0);
        check("arst_data", bus8.rpt_data, 0);
        check("arst_sel", bus8.rpt_sel, 0);
        #2 rst_n = 1'b1;
        step();
        push8(0, 0); push8(1, 0); push8(2, 0); push8(3, 0);
        run_report8("post_rst", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
